cmos_dvp_tx: RTL and testbench

//  DVP-style camera transmitter: the sending end of the byte-wide vsync/href/data interface that cmos_capture receives.

---
 rtl/cmos_dvp_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_cmos_dvp_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_dvp_tx.sv
`default_nettype none
// ============================================================================
// Module   : cmos_dvp_tx
// Purpose  : DVP-style camera transmitter. Serialises an RGB565 valid/ready
//            pixel stream into the byte-wide vsync/href/data interface, two
//            bytes per pixel with the high byte first. It frames lines and
//            blanking with vsync/href. It serves as an on-chip sensor model
//            and as a DVP output stage for pattern sources.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1   pixel/byte clock, rising edge
//   rst         in   1   asynchronous reset, active high
//   enable      in   1   permits a new frame to start (sampled in IDLE only)
//   s_valid     in   1   input pixel valid
//   s_ready     out  1   input pixel accepted when s_valid & s_ready
//   s_sof       in   1   first pixel of a frame, qualified by s_valid
//   s_data      in  16   RGB565 pixel
//   cmos_vsync  out  1   frame valid
//   cmos_href   out  1   line valid
//   cmos_data   out  8   pixel[15:8] then pixel[7:0]; 0 while href is low
//   frame_done  out  1   single-cycle pulse on the cycle vsync falls
//   underflow   out  1   sticky starved-slot flag, cleared at frame start
// ============================================================================
module cmos_dvp_tx #(
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 720,
    parameter int H_BLANK    = 10,
    parameter int V_FRONT    = 5,
    parameter int V_BACK     = 5,
    parameter int FRAME_GAP  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_sof,
    input  logic [15:0] s_data,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_data,
    output logic        frame_done,
    output logic        underflow
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int c_COL_W = $clog2(2 * IMG_WIDTH);
    localparam int c_ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    // One shared blanking counter covers every non-LINE timed state, so it
    // is sized for the longest of them (VBACK runs V_BACK+1 cycles).
    localparam int c_M1      = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int c_M2      = ((V_BACK + 1) > FRAME_GAP) ? (V_BACK + 1) : FRAME_GAP;
    localparam int c_CNT_MAX = (c_M1 > c_M2) ? c_M1 : c_M2;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(2 * IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);

    // vsync rises on entry to VFRONT, and href trails the first LINE cycle
    // by one register stage. VFRONT therefore occupies V_FRONT-1 cycles,
    // and it is skipped entirely when V_FRONT is 1.
    localparam logic [c_CNT_W-1:0] c_VF_LAST  = c_CNT_W'((V_FRONT > 1) ? (V_FRONT - 2) : 0);
    localparam logic [c_CNT_W-1:0] c_HB_LAST  = c_CNT_W'(H_BLANK - 1);
    // VBACK covers the cycle that drives the last byte plus V_BACK cycles
    // of vsync after href has fallen.
    localparam logic [c_CNT_W-1:0] c_VB_LAST  = c_CNT_W'(V_BACK);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(FRAME_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_VFRONT = 3'd1;
    localparam logic [2:0] c_ST_LINE   = 3'd2;
    localparam logic [2:0] c_ST_HBLANK = 3'd3;
    localparam logic [2:0] c_ST_VBACK  = 3'd4;
    localparam logic [2:0] c_ST_GAP    = 3'd5;

    logic [2:0]         r_state;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_lo;
    logic               r_vsync;
    logic               r_href;
    logic [7:0]         r_data;
    logic               r_frame_done;
    logic               r_underflow;
    logic               w_ready;
    logic               w_start;
    logic               w_phase;

    // Column LSB is the byte phase: 0 fetches a pixel, 1 replays its low byte.
    assign w_phase = r_col[0];
    assign w_start = enable & s_valid & s_sof;

    // ------------------------------------------------------------------------
    // Ready generation. This is the only combinational output: the
    // handshake must respond in the same cycle. In IDLE, non-sof pixels
    // are drained so that a misaligned source falls back onto a frame
    // boundary. The sof pixel itself is held for the first LINE slot.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            c_ST_IDLE: w_ready = s_valid & ~s_sof;
            c_ST_LINE: w_ready = ~w_phase;
            default:   w_ready = 1'b0;
        endcase
    end

    assign s_ready = w_ready;

    // ------------------------------------------------------------------------
    // Frame sequencer and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_cnt        <= '0;
            r_lo         <= 8'h00;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            // href/data default low; only LINE cycles drive a byte.
            r_href       <= 1'b0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_vsync     <= 1'b1;
                        r_underflow <= 1'b0;
                        r_cnt       <= '0;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_state     <= (V_FRONT > 1) ? c_ST_VFRONT : c_ST_LINE;
                    end
                end

                c_ST_VFRONT: begin
                    if (r_cnt == c_VF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_LINE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_LINE: begin
                    r_href <= 1'b1;
                    if (!w_phase) begin
                        if (s_valid) begin
                            r_data <= s_data[15:8];
                            r_lo   <= s_data[7:0];
                        end else begin
                            // Starved slot: emit a zero pixel and keep the
                            // line length fixed rather than stretching it.
                            r_data      <= 8'h00;
                            r_lo        <= 8'h00;
                            r_underflow <= 1'b1;
                        end
                    end else begin
                        r_data <= r_lo;
                    end

                    if (r_col == c_COL_LAST) begin
                        r_col <= '0;
                        r_cnt <= '0;
                        if (r_row == c_ROW_LAST) begin
                            r_row   <= '0;
                            r_state <= c_ST_VBACK;
                        end else begin
                            r_row   <= r_row + c_ROW_ONE;
                            r_state <= c_ST_HBLANK;
                        end
                    end else begin
                        r_col <= r_col + c_COL_ONE;
                    end
                end

                c_ST_HBLANK: begin
                    if (r_cnt == c_HB_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_LINE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_VBACK: begin
                    if (r_cnt == c_VB_LAST) begin
                        r_cnt        <= '0;
                        r_vsync      <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= c_ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_vsync <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cmos_vsync = r_vsync;
    assign cmos_href  = r_href;
    assign cmos_data  = r_data;
    assign frame_done = r_frame_done;
    assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_cmos_dvp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_dvp_tx
// Purpose  : Self-checking bench for cmos_dvp_tx. It drives a randomized
//            pixel source and compares the observed DVP waveform against
//            frame-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_dvp_tx;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 3;
    localparam int VF = 2;
    localparam int VB = 2;
    localparam int FG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic [15:0] s_data;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic        frame_done;
    logic        underflow;

    always #5 clk = ~clk;

    cmos_dvp_tx #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .H_BLANK   (HB),
        .V_FRONT   (VF),
        .V_BACK    (VB),
        .FRAME_GAP (FG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sof     (s_sof),
        .s_data    (s_data),
        .cmos_vsync(cmos_vsync),
        .cmos_href (cmos_href),
        .cmos_data (cmos_data),
        .frame_done(frame_done),
        .underflow (underflow)
    );

    typedef struct packed {
        logic        sof;
        logic        starve;   // source withholds valid for one slot before this pixel
        logic [15:0] data;
    } pix_t;

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic       fd;
        logic       uf;
        logic       acc;
        logic [7:0] d;
    } obs_t;

    pix_t        src_q[$];
    obs_t        log_q[$];
    logic [15:0] exp_q[$];   // expected pixel per slot, starved slot = 0
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_fd_cyc   = 0;
    int          last_rise_cyc = 0;
    logic        prev_vs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (src_q.size() == 0) begin
            s_valid = 1'b0;
            s_sof   = 1'b0;
            s_data  = 16'h0000;
        end else begin
            s_valid = ~src_q[0].starve;
            s_sof   = src_q[0].sof;
            s_data  = src_q[0].data;
        end
    endtask

    // One clock: sample on the falling edge, then update inputs after the rise.
    task automatic tick();
        obs_t o;
        @(negedge clk);
        o.vs  = cmos_vsync;
        o.hr  = cmos_href;
        o.fd  = frame_done;
        o.uf  = underflow;
        o.d   = cmos_data;
        o.acc = s_valid & s_ready;
        log_q.push_back(o);
        if (o.fd) last_fd_cyc = cyc;
        if (o.vs && !prev_vs) last_rise_cyc = cyc;
        prev_vs = o.vs;
        if (src_q.size() != 0) begin
            if (s_valid && s_ready) src_q.delete(0);
            else if (src_q[0].starve && s_ready) src_q[0].starve = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    // Queue npre stray pixels, then one frame; build the expected slot list.
    task automatic push_frame(input int npre, input int starve_at);
        pix_t p;
        exp_q.delete();
        for (int i = 0; i < npre; i++) begin
            p.sof = 1'b0; p.starve = 1'b0; p.data = 16'($urandom);
            src_q.push_back(p);
        end
        for (int i = 0; i < W * H; i++) begin
            p.sof = (i == 0); p.starve = (i == starve_at); p.data = 16'($urandom);
            src_q.push_back(p);
            if (i == starve_at) exp_q.push_back(16'h0000);
            exp_q.push_back(p.data);
        end
        while (exp_q.size() > W * H) void'(exp_q.pop_back());
        drive();
    endtask

    task automatic run_frame(input string tag);
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (log_q[log_q.size()-1].fd) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        tick();
        tick();
    endtask

    task automatic check_frame(input string tag);
        int         rv  = -1;
        int         vf  = -1;
        int         rs[$];
        int         re[$];
        logic [7:0] bytes[$];
        int         bad = 0;
        int         fdc = 0;
        int         fdi = -1;
        logic [15:0] pix;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].vs && rv < 0) rv = i;
            if (!log_q[i].vs && rv >= 0 && vf < 0) vf = i;
            if (log_q[i].hr && (i == 0 || !log_q[i-1].hr)) rs.push_back(i);
            if (!log_q[i].hr && i > 0 && log_q[i-1].hr) re.push_back(i);
            if (log_q[i].hr) bytes.push_back(log_q[i].d);
            if ((!log_q[i].hr && log_q[i].d != 8'h00) || (log_q[i].hr && !log_q[i].vs)) bad++;
            if (log_q[i].fd) begin fdc++; fdi = i; end
        end
        chk({tag, "_vsync_rose"}, 32'(rv >= 0), 32'd1);
        chk({tag, "_href_runs"},  32'(rs.size()), 32'(H));
        chk({tag, "_href_falls"}, 32'(re.size()), 32'(H));
        if (rs.size() == H && re.size() == H && rv >= 0) begin
            for (int r = 0; r < H; r++) begin
                chk({tag, "_line_len"}, 32'(re[r] - rs[r]), 32'(2 * W));
                if (r > 0) chk({tag, "_hblank"}, 32'(rs[r] - re[r-1]), 32'(HB));
            end
            chk({tag, "_vfront"}, 32'(rs[0] - rv), 32'(VF));
            chk({tag, "_vback"},  32'(vf - re[H-1]), 32'(VB));
        end
        chk({tag, "_fd_count"}, 32'(fdc), 32'd1);
        chk({tag, "_fd_at_fall"}, 32'(fdi), 32'(vf));
        chk({tag, "_idle_data_or_href"}, 32'(bad), 32'd0);
        chk({tag, "_byte_count"}, 32'(bytes.size()), 32'(2 * W * H));
        for (int k = 0; k < W * H; k++) begin
            if (2 * k + 1 < bytes.size()) begin
                pix = {bytes[2*k], bytes[2*k+1]};
                chk($sformatf("%s_pix%0d", tag, k), 32'(pix), 32'(exp_q[k]));
            end
        end
    endtask

    initial begin
        int cnt;
        int n;
        int rises;
        int fd_prev;
        int rv;

        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vsync", 32'(cmos_vsync), 32'd0);
        chk("rst_href",  32'(cmos_href),  32'd0);
        chk("rst_data",  32'(cmos_data),  32'd0);
        chk("rst_fd",    32'(frame_done), 32'd0);
        chk("rst_uf",    32'(underflow),  32'd0);
        chk("rst_ready", 32'(s_ready),    32'd0);
        rst = 1'b0;
        enable = 1'b1;

        // Always-valid source, frame starts with its sof pixel.
        log_q.delete();
        push_frame(0, -1);
        run_frame("t1");
        check_frame("t1");
        chk("t1_uf", 32'(underflow), 32'd0);
        chk("t1_src_empty", 32'(src_q.size()), 32'd0);

        // Three stray pixels ahead of sof are drained while vsync is low.
        fd_prev = last_fd_cyc;
        log_q.delete();
        push_frame(3, -1);
        run_frame("t4");
        check_frame("t4");
        cnt = 0;
        foreach (log_q[i]) if (log_q[i].acc && !log_q[i].vs) cnt++;
        chk("t4_flushed", 32'(cnt), 32'd3);
        chk("t4_gap_min", 32'((last_rise_cyc - fd_prev) >= FG), 32'd1);

        // Starve the third slot of line 0.
        log_q.delete();
        push_frame(0, 2);
        run_frame("t3");
        check_frame("t3");
        chk("t3_uf_sticky", 32'(underflow), 32'd1);
        chk("t3_leftover", 32'(src_q.size()), 32'd1);

        // Drop enable mid-frame; underflow clears on the new frame start.
        log_q.delete();
        push_frame(0, -1);
        n = 0;
        while (!cmos_vsync && n < 50) begin tick(); n++; end
        chk("t5_started", 32'(cmos_vsync), 32'd1);
        repeat (3) tick();
        enable = 1'b0;
        run_frame("t5");
        check_frame("t5");
        rv = -1;
        foreach (log_q[i]) if (log_q[i].vs && rv < 0) rv = i;
        if (rv > 0) begin
            chk("t5_uf_before_start", 32'(log_q[rv-1].uf), 32'd1);
            chk("t5_uf_cleared", 32'(log_q[rv].uf), 32'd0);
        end
        log_q.delete();
        push_frame(0, -1);
        repeat (30) tick();
        cnt = 0;
        foreach (log_q[i]) if (log_q[i].vs) cnt++;
        chk("t5_blocked_vsync", 32'(cnt), 32'd0);
        chk("t5_sof_held", 32'(src_q.size()), 32'(W * H));
        log_q.delete();
        enable = 1'b1;
        run_frame("t5b");
        check_frame("t5b");

        // Async reset in the middle of row 1.
        log_q.delete();
        push_frame(0, -1);
        rises = 0;
        n = 0;
        while (rises < 2 && n < 100) begin
            tick();
            n++;
            if (log_q[log_q.size()-1].hr && (log_q.size() == 1 || !log_q[log_q.size()-2].hr)) rises++;
        end
        chk("t6_row1_reached", 32'(rises), 32'd2);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_vsync", 32'(cmos_vsync), 32'd0);
        chk("t6_rst_href",  32'(cmos_href),  32'd0);
        chk("t6_rst_data",  32'(cmos_data),  32'd0);
        log_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        cnt = 0;
        n = 0;
        foreach (log_q[i]) begin
            if (log_q[i].fd) cnt++;
            if (log_q[i].vs) n++;
        end
        chk("t6_no_fd", 32'(cnt), 32'd0);
        chk("t6_no_vsync", 32'(n), 32'd0);
        chk("t6_stray_flushed", 32'(src_q.size()), 32'd0);
        log_q.delete();
        push_frame(0, -1);
        run_frame("t6b");
        check_frame("t6b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
